// File: rtl/parse_pkg.sv
// Shared constants for the parsing datapath and its sequencer:
// opcodes, mux encodings, phase values, FSM states and the control word.
package parse_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDN  = 3'b010;
    localparam logic [2:0] OP_NEG  = 3'b011;
    localparam logic [2:0] OP_STS  = 3'b100;
    localparam logic [2:0] OP_HIV  = 3'b101;
    localparam logic [2:0] OP_HIS  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] MUXV_ADDR  = 2'b00;
    localparam logic [1:0] MUXV_NIB   = 2'b01;
    localparam logic [1:0] MUXV_STATE = 2'b10;
    localparam logic [1:0] MUXV_NEG   = 2'b11;

    // T-phase writes VAR[0]; E-phase writes VAR[1] and is the only phase HI may load in
    localparam logic PHASE_T = 1'b0;
    localparam logic PHASE_E = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC0 = 2'd2,
        ST_EXEC1 = 2'd3
    } state_t;

    typedef struct packed {
        logic       flag_b;
        logic [1:0] mux_var;
        logic       en_d4;
        logic       en_var3;
        logic       en_op;
        logic       mux_hi;
        logic       en_hi;
    } ctrl_t;

endpackage

// File: rtl/parse_sequencer_if.sv
// Program-memory fetch handshake between the sequencer (master) and memory (slave).
interface parse_sequencer_if #(parameter int ADDR_W = 8);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/parse_decode.sv
// Combinational opcode/phase decoder producing the datapath control word.
module parse_decode
    import parse_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic       operand0,
    input  logic       active,
    input  logic       phase,
    output ctrl_t      ctrl
);

    // Each opcode owns exactly one phase; everything outside it stays zero
    always_comb begin
        ctrl = '0;
        if (active) begin
            case (opcode)
                OP_LDA: if (phase == PHASE_T) begin
                    ctrl.mux_var = MUXV_ADDR;
                    ctrl.en_op   = 1'b1;
                    ctrl.en_var3 = 1'b1;
                    ctrl.en_d4   = 1'b1;
                end
                OP_LDN: if (phase == PHASE_T) begin
                    ctrl.mux_var = MUXV_NIB;
                    ctrl.en_var3 = 1'b1;
                end
                OP_NEG: if (phase == PHASE_E) begin
                    ctrl.mux_var = MUXV_NEG;
                    ctrl.en_var3 = 1'b1;
                    ctrl.en_d4   = 1'b1;
                end
                OP_STS: if (phase == PHASE_E) begin
                    ctrl.mux_var = MUXV_STATE;
                    ctrl.flag_b  = operand0;
                    ctrl.en_var3 = 1'b1;
                    ctrl.en_d4   = 1'b1;
                end
                OP_HIV: if (phase == PHASE_E) begin
                    ctrl.mux_hi = 1'b0;
                    ctrl.en_hi  = 1'b1;
                end
                OP_HIS: if (phase == PHASE_E) begin
                    ctrl.mux_hi = 1'b1;
                    ctrl.en_hi  = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/parse_sequencer.sv
// Fetch/execute sequencer for the parsing datapath: fetches opcode bytes over
// a req/ack handshake and steps each through a T-phase and an E-phase.
module parse_sequencer
    import parse_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              abort,
    parse_sequencer_if.master mem,
    output logic              cycle,
    output logic              flag_b,
    output logic [1:0]        mux_var,
    output logic              en_d4,
    output logic              en_var3,
    output logic              en_op,
    output logic              mux_hi,
    output logic              en_hi,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        instr_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        opcode;
    logic              operand0;
    ctrl_t             ctrl;

    // abort outranks every transition and suppresses the done/err pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            wait_cnt  <= '0;
            instr_cnt <= '0;
            opcode    <= OP_NOP;
            operand0  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        state     <= ST_FETCH;
                        pc        <= start_pc;
                        instr_cnt <= '0;
                        wait_cnt  <= '0;
                    end
                    ST_FETCH: begin
                        if (mem.mem_ack) begin
                            opcode   <= mem.mem_rdata[7:5];
                            operand0 <= mem.mem_rdata[0];
                            state    <= ST_EXEC0;
                        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                            state <= ST_IDLE;
                            err   <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_EXEC0: state <= ST_EXEC1;
                    ST_EXEC1: begin
                        if (instr_cnt != 8'hFF) begin
                            instr_cnt <= instr_cnt + 8'd1;
                        end
                        wait_cnt <= '0;
                        if (opcode == OP_HALT) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            pc    <= pc + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem.mem_req  = (state == ST_FETCH);
    assign mem.mem_addr = pc;
    assign busy         = (state != ST_IDLE);
    assign cycle        = (state == ST_EXEC1) ? PHASE_E : PHASE_T;

    parse_decode u_decode (
        .opcode   (opcode),
        .operand0 (operand0),
        .active   ((state == ST_EXEC0) || (state == ST_EXEC1)),
        .phase    (cycle),
        .ctrl     (ctrl)
    );

    assign flag_b  = ctrl.flag_b;
    assign mux_var = ctrl.mux_var;
    assign en_d4   = ctrl.en_d4;
    assign en_var3 = ctrl.en_var3;
    assign en_op   = ctrl.en_op;
    assign mux_hi  = ctrl.mux_hi;
    assign en_hi   = ctrl.en_hi;

endmodule
